// File: rtl/mult_div_unit_pkg.sv
// Shared encodings and constants for the iterative multiply/divide unit.
// Op decode helpers keep the bit meaning of the opcode in one place.
package mult_div_unit_pkg;

   localparam int MDU_WIDTH   = 32;
   localparam int MDU_LATENCY = MDU_WIDTH + 2;

   typedef enum logic [1:0] {
      OP_MULT  = 2'b00,
      OP_MULTU = 2'b01,
      OP_DIV   = 2'b10,
      OP_DIVU  = 2'b11
   } mdu_op_e;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      RUN  = 2'b01,
      FIX  = 2'b10,
      DONE = 2'b11
   } mdu_state_e;

   function automatic logic op_is_div(input logic [1:0] op);
      return op[1];
   endfunction

   function automatic logic op_is_signed(input logic [1:0] op);
      return ~op[0];
   endfunction

endpackage

// File: rtl/mdu_abs_neg.sv
// Conditional two's-complement negate; yields magnitudes from signed operands
// and re-applies result signs after the unsigned iteration.
module mdu_abs_neg #(
   parameter int W = 32
) (
   input  logic [W-1:0] i_val,
   input  logic         i_neg,
   output logic [W-1:0] o_val
);

   assign o_val = i_neg ? (~i_val + W'(1)) : i_val;

endmodule

// File: rtl/mult_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU: one shift-add or restoring shift-subtract step
// per cycle on magnitudes, then a single fix-up cycle for signs and divide corners.
module mult_div_unit
   import mult_div_unit_pkg::*;
#(
   parameter int WIDTH = MDU_WIDTH
) (
   input  logic             Clk,
   input  logic             Reset,
   input  logic             Start,
   input  logic [1:0]       Op,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   output logic             Busy,
   output logic             Done,
   output logic [WIDTH-1:0] Upper,
   output logic [WIDTH-1:0] Lower
);

   localparam int               CW   = $clog2(WIDTH);
   localparam logic [CW-1:0]    LAST = CW'(WIDTH - 1);
   localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

   mdu_state_e           r_state;
   logic [CW-1:0]        r_cnt;
   logic [1:0]           r_op;
   logic [2*WIDTH-1:0]   r_acc;
   logic [WIDTH-1:0]     r_opnd;
   logic [WIDTH-1:0]     r_a_orig;
   logic                 r_neg_q;
   logic                 r_neg_r;
   logic                 r_b_zero;
   logic                 r_ovf;
   logic                 r_busy;
   logic                 r_done;
   logic [WIDTH-1:0]     r_upper;
   logic [WIDTH-1:0]     r_lower;

   logic                 w_sgn;
   logic [WIDTH-1:0]     w_mag_a;
   logic [WIDTH-1:0]     w_mag_b;
   logic [2*WIDTH-1:0]   w_prod;
   logic [WIDTH-1:0]     w_quo;
   logic [WIDTH-1:0]     w_rem;
   logic [WIDTH:0]       w_add;
   logic [WIDTH:0]       w_shift;
   logic [WIDTH:0]       w_diff;
   logic [2*WIDTH-1:0]   w_mul_nxt;
   logic [2*WIDTH-1:0]   w_div_nxt;
   logic [WIDTH-1:0]     w_upper;
   logic [WIDTH-1:0]     w_lower;

   assign w_sgn = op_is_signed(Op);

   mdu_abs_neg #(.W(WIDTH)) u_abs_a (
      .i_val(A), .i_neg(w_sgn & A[WIDTH-1]), .o_val(w_mag_a)
   );

   mdu_abs_neg #(.W(WIDTH)) u_abs_b (
      .i_val(B), .i_neg(w_sgn & B[WIDTH-1]), .o_val(w_mag_b)
   );

   mdu_abs_neg #(.W(2*WIDTH)) u_fix_p (
      .i_val(r_acc), .i_neg(r_neg_q), .o_val(w_prod)
   );

   mdu_abs_neg #(.W(WIDTH)) u_fix_q (
      .i_val(r_acc[WIDTH-1:0]), .i_neg(r_neg_q), .o_val(w_quo)
   );

   mdu_abs_neg #(.W(WIDTH)) u_fix_r (
      .i_val(r_acc[2*WIDTH-1:WIDTH]), .i_neg(r_neg_r), .o_val(w_rem)
   );

   // Multiply: acc = {partial, multiplier}; add multiplicand on LSB, shift right.
   assign w_add     = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_opnd} : '0);
   assign w_mul_nxt = {w_add, r_acc[WIDTH-1:1]};

   // Divide: acc = {remainder, dividend/quotient}; shift left, trial subtract.
   assign w_shift   = r_acc[2*WIDTH-1:WIDTH-1];
   assign w_diff    = w_shift - {1'b0, r_opnd};
   assign w_div_nxt = w_diff[WIDTH]
                    ? {w_shift[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b0}
                    : {w_diff[WIDTH-1:0],  r_acc[WIDTH-2:0], 1'b1};

   always_comb begin
      w_upper = w_prod[2*WIDTH-1:WIDTH];
      w_lower = w_prod[WIDTH-1:0];
      if (op_is_div(r_op)) begin
         if (r_b_zero) begin
            w_upper = r_a_orig;
            w_lower = '1;
         end else if (r_ovf) begin
            w_upper = '0;
            w_lower = MIN_NEG;
         end else begin
            w_upper = w_rem;
            w_lower = w_quo;
         end
      end
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         r_state  <= IDLE;
         r_cnt    <= '0;
         r_op     <= '0;
         r_acc    <= '0;
         r_opnd   <= '0;
         r_a_orig <= '0;
         r_neg_q  <= 1'b0;
         r_neg_r  <= 1'b0;
         r_b_zero <= 1'b0;
         r_ovf    <= 1'b0;
         r_busy   <= 1'b0;
         r_done   <= 1'b0;
         r_upper  <= '0;
         r_lower  <= '0;
      end else begin
         r_done <= 1'b0;
         unique case (r_state)
            IDLE, DONE: begin
               if (Start) begin
                  r_state  <= RUN;
                  r_busy   <= 1'b1;
                  r_cnt    <= '0;
                  r_op     <= Op;
                  r_acc    <= {{WIDTH{1'b0}}, op_is_div(Op) ? w_mag_a : w_mag_b};
                  r_opnd   <= op_is_div(Op) ? w_mag_b : w_mag_a;
                  r_a_orig <= A;
                  r_neg_q  <= w_sgn & (A[WIDTH-1] ^ B[WIDTH-1]);
                  r_neg_r  <= w_sgn & A[WIDTH-1];
                  r_b_zero <= (B == '0);
                  r_ovf    <= (Op == OP_DIV) && (A == MIN_NEG) && (B == '1);
               end else begin
                  r_state <= IDLE;
                  r_busy  <= 1'b0;
               end
            end
            RUN: begin
               r_acc <= op_is_div(r_op) ? w_div_nxt : w_mul_nxt;
               r_cnt <= r_cnt + CW'(1);
               if (r_cnt == LAST) r_state <= FIX;
            end
            FIX: begin
               r_upper <= w_upper;
               r_lower <= w_lower;
               r_busy  <= 1'b0;
               r_done  <= 1'b1;
               r_state <= DONE;
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign Busy  = r_busy;
   assign Done  = r_done;
   assign Upper = r_upper;
   assign Lower = r_lower;

endmodule

// File: tb/tb_mult_div_unit.sv
// Randomized and directed check of mult_div_unit against an arithmetic model
// built from signed/unsigned 64-bit products and truncating division.
module tb_mult_div_unit;
   import mult_div_unit_pkg::*;

   logic        Clk = 1'b0;
   logic        Reset = 1'b1;
   logic        Start = 1'b0;
   logic [1:0]  Op = 2'b00;
   logic [31:0] A = '0;
   logic [31:0] B = '0;
   logic        Busy, Done;
   logic [31:0] Upper, Lower;

   int nvec = 0;
   int nerr = 0;

   mult_div_unit #(.WIDTH(32)) dut (
      .Clk(Clk), .Reset(Reset), .Start(Start), .Op(Op), .A(A), .B(B),
      .Busy(Busy), .Done(Done), .Upper(Upper), .Lower(Lower)
   );

   always #5 Clk = ~Clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      nvec++;
      if (obs !== exp) begin
         nerr++;
         $display("FAIL %s: got %h want %h", tag, obs, exp);
      end
   endtask

   // Reference: {HI, LO} from plain arithmetic.
   function automatic logic [63:0] model(input logic [1:0] op, input logic [31:0] a,
                                         input logic [31:0] b);
      longint p;
      int     sq, sr;
      logic [63:0] up;
      case (op)
         OP_MULT: begin
            p = longint'($signed(a)) * longint'($signed(b));
            return p;
         end
         OP_MULTU: begin
            up = {32'b0, a} * {32'b0, b};
            return up;
         end
         default: begin
            if (b == 0) return {a, 32'hFFFF_FFFF};
            if (op == OP_DIV && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
               return {32'h0, 32'h8000_0000};
            if (op == OP_DIV) begin
               sq = $signed(a) / $signed(b);
               sr = $signed(a) % $signed(b);
               return {sr, sq};
            end
            return {a % b, a / b};
         end
      endcase
   endfunction

   // Drive Start for one cycle (cycle n); returns at the negedge of cycle n+1.
   task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
      @(negedge Clk);
      Start = 1'b1; Op = op; A = a; B = b;
      @(negedge Clk);
      Start = 1'b0; Op = 2'($urandom); A = $urandom; B = $urandom;
   endtask

   // Called at the negedge of cycle n+cyc0; waits for Done, checks latency,
   // Busy over the run, and the result. Leaves the bench in the Done cycle.
   task automatic collect(input string tag, input logic [63:0] exp, input int cyc0);
      int cyc = cyc0;
      bit busy_ok = 1'b1;
      while (!Done && cyc < 120) begin
         if (!Busy) busy_ok = 1'b0;
         @(negedge Clk);
         cyc++;
      end
      chk({tag, ".lat"}, 64'(cyc), 64'(MDU_LATENCY));
      chk({tag, ".busy"}, {63'b0, busy_ok & ~Busy}, 64'd1);
      chk({tag, ".res"}, {Upper, Lower}, exp);
   endtask

   initial begin
      logic [1:0]  op;
      logic [31:0] a, b;
      logic [63:0] hold;
      bit          seen;

      repeat (3) @(negedge Clk);
      chk("rst", {28'b0, Busy, Done, 2'b0, Upper, Lower}, 64'h0);
      Reset = 1'b0;

      // Directed corner values.
      issue(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      collect("multu_max", 64'hFFFF_FFFE_0000_0001, 1);
      hold = {Upper, Lower};
      @(negedge Clk);
      chk("done_pulse", {63'b0, Done}, 64'd0);
      chk("hold", {Upper, Lower}, hold);

      issue(OP_MULT, 32'hFFFF_FFFD, 32'd7);
      collect("mult_neg", 64'hFFFF_FFFF_FFFF_FFEB, 1);
      issue(OP_MULT, 32'h8000_0000, 32'h8000_0000);
      collect("mult_min", 64'h4000_0000_0000_0000, 1);
      issue(OP_DIV, 32'hFFFF_FFF9, 32'd2);
      collect("div_neg", 64'hFFFF_FFFF_FFFF_FFFD, 1);
      issue(OP_DIVU, 32'd100, 32'd7);
      collect("divu", {32'd2, 32'd14}, 1);
      issue(OP_DIVU, 32'd100, 32'd0);
      collect("divu_by0", {32'h64, 32'hFFFF_FFFF}, 1);
      issue(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
      collect("div_ovf", {32'h0, 32'h8000_0000}, 1);
      issue(OP_DIV, 32'hFFFF_FF00, 32'd0);
      collect("div_by0", {32'hFFFF_FF00, 32'hFFFF_FFFF}, 1);

      // Start while busy is ignored.
      issue(OP_MULTU, 32'd6, 32'd7);
      repeat (4) @(negedge Clk);
      Start = 1'b1; Op = OP_DIVU; A = 32'd9; B = 32'd3;
      @(negedge Clk);
      Start = 1'b0;
      collect("ignore", 64'd42, 6);

      // Back-to-back accept in the Done cycle.
      issue(OP_MULT, 32'd5, 32'hFFFF_FFFE);
      collect("b2b_first", model(OP_MULT, 32'd5, 32'hFFFF_FFFE), 1);
      Start = 1'b1; Op = OP_DIV; A = 32'd1000; B = 32'hFFFF_FFF9;
      @(negedge Clk);
      Start = 1'b0;
      collect("b2b_second", model(OP_DIV, 32'd1000, 32'hFFFF_FFF9), 1);

      // Reset mid-operation discards the op.
      issue(OP_MULTU, 32'h1234_5678, 32'h9ABC_DEF0);
      repeat (9) @(negedge Clk);
      Reset = 1'b1;
      @(negedge Clk);
      Reset = 1'b0;
      chk("mid_rst", {28'b0, Busy, Done, 2'b0, Upper, Lower}, 64'h0);
      seen = 1'b0;
      repeat (40) begin
         @(negedge Clk);
         if (Done || Busy) seen = 1'b1;
      end
      chk("no_done_after_rst", {63'b0, seen}, 64'd0);

      // Randomized operations with occasional corner operands.
      repeat (60) begin
         op = 2'($urandom);
         a = $urandom;
         b = $urandom;
         case ($urandom_range(0, 7))
            0: b = 32'h0;
            1: a = 32'h8000_0000;
            2: b = 32'hFFFF_FFFF;
            3: b = $urandom_range(1, 15);
            default: ;
         endcase
         issue(op, a, b);
         collect($sformatf("rand op%0d %h %h", op, a, b), model(op, a, b), 1);
      end

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
